floor_request_scheduler: RTL and testbench
==========================================

Name: floor_request_scheduler

Overview:
Upstream feeder for the elevator state machine. Latches floor calls from the car and hall buttons into a pending mask. Selects the next target floor using SCAN (keep travelling in the current direction while any call remains ahead) and drives requested_floor into the elevator FSM. On arrival it clears the served call and runs a door-open dwell timer.

Parameters:
NUM_FLOORS, 10, number of floors served; legal range 2..16; floors are numbered 0..NUM_FLOORS-1
DWELL_CYCLES, 8, clock cycles door_open stays high per stop; legal range 1..255

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
call_valid  input  1  one-cycle strobe: a button press is present on call_floor
call_floor  input  4  floor number of the press
current_floor  input  4  car position from the position sensor; same signal the elevator FSM uses
requested_floor  output  4  target floor to the elevator FSM
request_pending  output  1  high when pending_mask is nonzero
pending_mask  output  NUM_FLOORS  one bit per floor with an outstanding call
dir_up  output  1  SCAN direction: 1 = up, 0 = down
door_open  output  1  high during the dwell at a stop

Behaviour:
- Reset values (synchronous, takes priority over all other inputs, may be asserted mid-operation):
  - pending_mask = 0, state = IDLE, dir_up = 1, door_open = 0, dwell counter = 0.
  - requested_floor tracks current_floor, so the FSM sees no request.
- Call latching:
  - call_valid=1 with call_floor < NUM_FLOORS sets pending_mask[call_floor]; visible the next cycle.
  - call_floor >= NUM_FLOORS is ignored.
  - A repeated call for an already-pending floor has no effect.
- States IDLE, SERVE, DWELL (2-bit register):
  - IDLE: door_open=0.
    - If pending_mask[current_floor] is set, go to DWELL.
    - Else if any other bit is set, go to SERVE.
  - SERVE: requested_floor comes from the SCAN selection.
    - When pending_mask[current_floor] is set, go to DWELL. This also covers an intermediate floor called while passing.
  - DWELL: door_open=1, requested_floor=current_floor.
    - On entry, clear pending_mask[current_floor] and load the counter with DWELL_CYCLES-1.
    - Decrement each cycle. At 0, go to SERVE if any bit remains, else IDLE.
    - door_open is high for exactly DWELL_CYCLES cycles.
- SCAN selection (combinational from registered pending_mask, dir_up and current_floor):
  - dir_up=1: nearest set bit strictly above current_floor. If none, nearest set bit below and flip dir_up to 0 at the next clock edge.
  - dir_up=0: the mirror case.
  - With no pending bits, requested_floor=current_floor and dir_up holds.
- Simultaneous events:
  - A call for current_floor while in DWELL is absorbed: the bit is not set and the counter reloads (door stays open longer).
  - A call for another floor in the same cycle as a clear is latched normally; set and clear never target the same bit.
- Width rule: floor compares are 4-bit unsigned. pending_mask bits beyond NUM_FLOORS do not exist.

Optional Feature:
Macro ELEVATOR_EMERGENCY_EN.
- Defined: adds input emergency (1 bit).
  - While it is high, pending_mask is cleared every cycle, new calls are ignored, and requested_floor is forced to 0.
  - door_open=0 until current_floor==0, then door_open=1 for as long as emergency stays high.
  - On deassertion, go to IDLE with dir_up=1.
- Undefined: no port and no logic; behaviour exactly as above.

Test Plan:
- Reset mid-DWELL with calls pending -> next cycle pending_mask=0, door_open=0, dir_up=1, requested_floor=current_floor.
- current_floor=0, call floor 5 -> request_pending=1, requested_floor=5, SERVE. Drive current_floor to 5 -> door_open high for exactly 8 cycles, bit 5 cleared, then IDLE.
- current_floor=4, dir_up=1, calls 2, 7, 6 pending -> requested_floor=6, then 7. After the dwell at 7, dir_up=0 and requested_floor=2.
- Call floor 3 while stopped in DWELL at floor 3 -> bit 3 stays 0, door_open extended by DWELL_CYCLES from the call.
- call_floor=12 with NUM_FLOORS=10 -> pending_mask unchanged. Call the current floor while IDLE -> DWELL entered with no movement.
- (ELEVATOR_EMERGENCY_EN) at floor 6 with calls 8 and 9 pending, assert emergency -> pending_mask=0, requested_floor=0, door_open=0. At floor 0, door_open=1 until release.

Source files
------------

// File: rtl/floor_request_scheduler_if.sv
// Call / target bus between the button panel, position sensor and
// the floor request scheduler that feeds the elevator FSM.
interface floor_request_scheduler_if #(
   parameter int NUM_FLOORS = 10
);
   logic                  call_valid;
   logic [3:0]            call_floor;
   logic [3:0]            current_floor;
   logic [3:0]            requested_floor;
   logic                  request_pending;
   logic [NUM_FLOORS-1:0] pending_mask;
   logic                  dir_up;
   logic                  door_open;

   modport master (
      output call_valid, call_floor, current_floor,
      input  requested_floor, request_pending, pending_mask,
      input  dir_up, door_open
   );

   modport slave (
      input  call_valid, call_floor, current_floor,
      output requested_floor, request_pending, pending_mask,
      output dir_up, door_open
   );
endinterface

// File: rtl/floor_request_scheduler.sv
// SCAN floor request scheduler with door dwell timer.
// Optional ELEVATOR_EMERGENCY_EN adds an emergency recall-to-ground input.
module floor_request_scheduler #(
   parameter int NUM_FLOORS   = 10,
   parameter int DWELL_CYCLES = 8
) (
   input logic clk,
   input logic reset,
`ifdef ELEVATOR_EMERGENCY_EN
   input logic emergency,
`endif
   floor_request_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DWELL = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [NUM_FLOORS-1:0] r_mask;
   logic [NUM_FLOORS-1:0] w_mask_nxt;
   logic                  r_dir_up;
   logic [7:0]            r_cnt;
   logic [15:0]           w_mask16;
   logic [15:0]           w_nxt16;
   logic                  w_here;
   logic                  w_any;
   logic                  w_emerg;
   logic                  w_call_ok;
   logic                  w_absorb;
   logic                  w_enter;
   logic                  w_up_found;
   logic                  w_dn_found;
   logic [3:0]            w_up_floor;
   logic [3:0]            w_dn_floor;
   logic [3:0]            w_cur;
   logic [3:0]            w_req;
   logic                  w_door;

`ifdef ELEVATOR_EMERGENCY_EN
   assign w_emerg = emergency;
`else
   assign w_emerg = 1'b0;
`endif

   assign w_cur     = bus.current_floor;
   assign w_mask16  = 16'(r_mask);
   assign w_here    = w_mask16[w_cur];
   assign w_any     = |r_mask;
   assign w_call_ok = bus.call_valid &&
                      ({1'b0, bus.call_floor} < 5'(NUM_FLOORS));
   // A call for the floor we are stopped at only keeps the door open
   assign w_absorb  = (r_state == DWELL) && w_call_ok &&
                      (bus.call_floor == w_cur);
   assign w_enter   = (w_next == DWELL) && (r_state != DWELL);

   // SCAN search: nearest pending floor above and below the car
   always_comb begin
      w_up_found = 1'b0;
      w_up_floor = w_cur;
      w_dn_found = 1'b0;
      w_dn_floor = w_cur;
      for (int i = 15; i >= 0; i--) begin
         if (w_mask16[i] && (4'(i) > w_cur)) begin
            w_up_found = 1'b1;
            w_up_floor = 4'(i);
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (w_mask16[i] && (4'(i) < w_cur)) begin
            w_dn_found = 1'b1;
            w_dn_floor = 4'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_here)     w_next = DWELL;
            else if (w_any) w_next = SERVE;
         end
         SERVE: begin
            if (w_here)      w_next = DWELL;
            else if (!w_any) w_next = IDLE;
         end
         DWELL: begin
            if (!w_absorb && (r_cnt == 8'd0))
               w_next = w_any ? SERVE : IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (w_emerg) w_next = IDLE;
   end

   // Outputs: target floor and door control
   always_comb begin
      w_req  = w_cur;
      w_door = 1'b0;
      unique case (r_state)
         SERVE: begin
            if (r_dir_up)
               w_req = w_up_found ? w_up_floor :
                       w_dn_found ? w_dn_floor : w_cur;
            else
               w_req = w_dn_found ? w_dn_floor :
                       w_up_found ? w_up_floor : w_cur;
         end
         DWELL:   w_door = 1'b1;
         default: w_req  = w_cur;
      endcase
      if (w_emerg) begin
         w_req  = 4'd0;
         w_door = (w_cur == 4'd0);
      end
   end

   // Pending mask update: latch new calls, clear the floor being served
   always_comb begin
      w_nxt16 = w_mask16;
      if (w_enter) w_nxt16[w_cur] = 1'b0;
      if (w_call_ok && !w_absorb &&
          !(w_enter && (bus.call_floor == w_cur)))
         w_nxt16[bus.call_floor] = 1'b1;
      w_mask_nxt = w_nxt16[NUM_FLOORS-1:0];
   end

   // Mask, direction and dwell counter registers
   always_ff @(posedge clk) begin
      if (reset || w_emerg) begin
         r_mask   <= '0;
         r_dir_up <= 1'b1;
         r_cnt    <= 8'd0;
      end else begin
         r_mask <= w_mask_nxt;
         if (r_dir_up && !w_up_found && w_dn_found)
            r_dir_up <= 1'b0;
         else if (!r_dir_up && !w_dn_found && w_up_found)
            r_dir_up <= 1'b1;
         if (w_enter || w_absorb)
            r_cnt <= 8'(DWELL_CYCLES - 1);
         else if ((r_state == DWELL) && (r_cnt != 8'd0))
            r_cnt <= r_cnt - 8'd1;
      end
   end

   assign bus.requested_floor = w_req;
   assign bus.request_pending = w_any;
   assign bus.pending_mask    = r_mask;
   assign bus.dir_up          = r_dir_up;
   assign bus.door_open       = w_door;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed testbench for floor_request_scheduler (NUM_FLOORS=10,
// DWELL_CYCLES=8); emergency scenario runs when ELEVATOR_EMERGENCY_EN is set.
module tb_floor_request_scheduler;

   logic clk;
   logic reset;
`ifdef ELEVATOR_EMERGENCY_EN
   logic emergency;
`endif
   int   pass_cnt;
   int   total_cnt;
   int   n;

   floor_request_scheduler_if #(.NUM_FLOORS(10)) bus ();

   floor_request_scheduler #(
      .NUM_FLOORS(10),
      .DWELL_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef ELEVATOR_EMERGENCY_EN
      .emergency(emergency),
`endif
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic call(input logic [3:0] f);
      bus.call_valid = 1'b1;
      bus.call_floor = f;
      tick();
      bus.call_valid = 1'b0;
   endtask

   task automatic count_door();
      n = 0;
      while (bus.door_open && n < 20) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.call_valid = 1'b0;
      bus.call_floor = 4'd0;
      bus.current_floor = 4'd3;
      tick();
      tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL rst_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.request_pending !== 1'b0) $display("FAIL rst_pend got %b exp 0", bus.request_pending); else pass_cnt++;
      total_cnt++; if (bus.door_open !== 1'b0) $display("FAIL rst_door got %b exp 0", bus.door_open); else pass_cnt++;
      total_cnt++; if (bus.dir_up !== 1'b1) $display("FAIL rst_dir got %b exp 1", bus.dir_up); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd3) $display("FAIL rst_req got %0d exp 3", bus.requested_floor); else pass_cnt++;
   endtask

   task automatic test_single_call();
      bus.current_floor = 4'd0;
      call(4'd5);
      total_cnt++; if (bus.pending_mask !== 10'h020) $display("FAIL single_mask got %h exp 020", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.request_pending !== 1'b1) $display("FAIL single_pend got %b exp 1", bus.request_pending); else pass_cnt++;
      tick();
      total_cnt++; if (bus.requested_floor !== 4'd5) $display("FAIL single_req got %0d exp 5", bus.requested_floor); else pass_cnt++;
      total_cnt++; if (bus.door_open !== 1'b0) $display("FAIL single_door_serve got %b exp 0", bus.door_open); else pass_cnt++;
      bus.current_floor = 4'd5;
      tick();
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL single_clear got %h exp 000", bus.pending_mask); else pass_cnt++;
      count_door();
      total_cnt++; if (n !== 8) $display("FAIL single_dwell got %0d exp 8", n); else pass_cnt++;
      total_cnt++; if (bus.request_pending !== 1'b0) $display("FAIL single_idle_pend got %b exp 0", bus.request_pending); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd5) $display("FAIL single_idle_req got %0d exp 5", bus.requested_floor); else pass_cnt++;
   endtask

   task automatic test_scan();
      bus.current_floor = 4'd4;
      call(4'd7);
      call(4'd6);
      call(4'd2);
      total_cnt++; if (bus.pending_mask !== 10'h0C4) $display("FAIL scan_mask got %h exp 0c4", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd6) $display("FAIL scan_req6 got %0d exp 6", bus.requested_floor); else pass_cnt++;
      total_cnt++; if (bus.dir_up !== 1'b1) $display("FAIL scan_dir_up got %b exp 1", bus.dir_up); else pass_cnt++;
      bus.current_floor = 4'd6;
      tick();
      total_cnt++; if (bus.pending_mask !== 10'h084) $display("FAIL scan_clear6 got %h exp 084", bus.pending_mask); else pass_cnt++;
      count_door();
      total_cnt++; if (n !== 8) $display("FAIL scan_dwell6 got %0d exp 8", n); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd7) $display("FAIL scan_req7 got %0d exp 7", bus.requested_floor); else pass_cnt++;
      bus.current_floor = 4'd7;
      tick();
      count_door();
      total_cnt++; if (bus.dir_up !== 1'b0) $display("FAIL scan_dir_flip got %b exp 0", bus.dir_up); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd2) $display("FAIL scan_req2 got %0d exp 2", bus.requested_floor); else pass_cnt++;
      total_cnt++; if (bus.pending_mask !== 10'h004) $display("FAIL scan_mask2 got %h exp 004", bus.pending_mask); else pass_cnt++;
      bus.current_floor = 4'd2;
      tick();
      count_door();
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL scan_done got %h exp 000", bus.pending_mask); else pass_cnt++;
   endtask

   task automatic test_reset_mid_dwell();
      bus.current_floor = 4'd9;
      call(4'd4);
      call(4'd9);
      tick();
      total_cnt++; if (bus.door_open !== 1'b1) $display("FAIL mid_door got %b exp 1", bus.door_open); else pass_cnt++;
      total_cnt++; if (bus.dir_up !== 1'b0) $display("FAIL mid_dir got %b exp 0", bus.dir_up); else pass_cnt++;
      total_cnt++; if (bus.pending_mask !== 10'h010) $display("FAIL mid_mask got %h exp 010", bus.pending_mask); else pass_cnt++;
      reset = 1'b1;
      bus.current_floor = 4'd7;
      tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL mid_rst_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.door_open !== 1'b0) $display("FAIL mid_rst_door got %b exp 0", bus.door_open); else pass_cnt++;
      total_cnt++; if (bus.dir_up !== 1'b1) $display("FAIL mid_rst_dir got %b exp 1", bus.dir_up); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd7) $display("FAIL mid_rst_req got %0d exp 7", bus.requested_floor); else pass_cnt++;
      tick();
   endtask

   task automatic test_absorb();
      bus.current_floor = 4'd3;
      call(4'd3);
      total_cnt++; if (bus.pending_mask !== 10'h008) $display("FAIL here_mask got %h exp 008", bus.pending_mask); else pass_cnt++;
      tick();
      total_cnt++; if (bus.door_open !== 1'b1) $display("FAIL here_door got %b exp 1", bus.door_open); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd3) $display("FAIL here_req got %0d exp 3", bus.requested_floor); else pass_cnt++;
      tick();
      tick();
      call(4'd3);
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL absorb_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      count_door();
      total_cnt++; if (n !== 8) $display("FAIL absorb_extend got %0d exp 8", n); else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      bus.current_floor = 4'd3;
      call(4'd12);
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL oor12_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      call(4'd10);
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL oor10_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.request_pending !== 1'b0) $display("FAIL oor_pend got %b exp 0", bus.request_pending); else pass_cnt++;
      call(4'd9);
      total_cnt++; if (bus.pending_mask !== 10'h200) $display("FAIL top_mask got %h exp 200", bus.pending_mask); else pass_cnt++;
      tick();
      total_cnt++; if (bus.requested_floor !== 4'd9) $display("FAIL top_req got %0d exp 9", bus.requested_floor); else pass_cnt++;
   endtask

`ifdef ELEVATOR_EMERGENCY_EN
   task automatic test_emergency();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.current_floor = 4'd6;
      call(4'd8);
      call(4'd9);
      emergency = 1'b1;
      call(4'd2);
      total_cnt++; if (bus.pending_mask !== 10'h000) $display("FAIL emg_mask got %h exp 000", bus.pending_mask); else pass_cnt++;
      total_cnt++; if (bus.requested_floor !== 4'd0) $display("FAIL emg_req got %0d exp 0", bus.requested_floor); else pass_cnt++;
      total_cnt++; if (bus.door_open !== 1'b0) $display("FAIL emg_door6 got %b exp 0", bus.door_open); else pass_cnt++;
      bus.current_floor = 4'd0;
      tick();
      tick();
      total_cnt++; if (bus.door_open !== 1'b1) $display("FAIL emg_door0 got %b exp 1", bus.door_open); else pass_cnt++;
      emergency = 1'b0;
      tick();
      total_cnt++; if (bus.door_open !== 1'b0) $display("FAIL emg_rel_door got %b exp 0", bus.door_open); else pass_cnt++;
      total_cnt++; if (bus.dir_up !== 1'b1) $display("FAIL emg_rel_dir got %b exp 1", bus.dir_up); else pass_cnt++;
   endtask
`endif

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
`ifdef ELEVATOR_EMERGENCY_EN
      emergency = 1'b0;
`endif
      test_reset();
      test_single_call();
      test_scan();
      test_reset_mid_dwell();
      test_absorb();
      test_out_of_range();
`ifdef ELEVATOR_EMERGENCY_EN
      test_emergency();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
